// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first.
// The input line is synchronised, each frame is found by its start-bit falling
// edge, and every bit is sampled at mid-period by an internal baud counter.
// A good byte is presented on rx_data with a one-cycle recv_flag strobe; a low
// stop bit produces a one-cycle frame_err strobe and leaves rx_data untouched.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ttl_rx_i,
  output logic [7:0] rx_data,
  output logic       recv_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        next_state;

  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  logic          fall;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  logic          cnt_clr;
  logic          cnt_inc;
  logic          idx_clr;
  logic          shift_en;
  logic          done_ok;
  logic          done_err;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  // All reset to 1 so a line held low at reset release looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= ttl_rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and datapath controls.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    idx_clr    = 1'b0;
    shift_en   = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          next_state = START;
          cnt_clr    = 1'b1;
          idx_clr    = 1'b1;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            next_state = IDLE;
          end else begin
            next_state = DATA;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (idx == 3'd7) begin
            next_state = STOP;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_clr    = 1'b1;
          next_state = IDLE;
          if (rx_s) begin
            done_ok = 1'b1;
          end else begin
            done_err = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Baud counter and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (idx_clr) begin
        idx <= '0;
      end else if (shift_en) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Data shift register, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
    end else if (shift_en) begin
      shift[idx] <= rx_s;
    end
  end

  // Result register and one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      recv_flag <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      recv_flag <= done_ok;
      frame_err <= done_err;
      if (done_ok) begin
        rx_data <= shift;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at BIT_CNT=16.
// The reference model records the line level at every clock edge and reads it
// back at the documented sample instants to predict each frame's outcome.
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = 8;
  localparam int HIST = 8192;

  typedef struct {
    int         t;
    logic [7:0] d;
  } rx_ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ttl_rx_i;
  logic [7:0] rx_data;
  logic       recv_flag;
  logic       frame_err;
  logic       busy;

  int         cyc = 0;
  bit         hist [0:HIST-1];
  rx_ev_t     rq[$];
  int         eq[$];
  int         both_cnt = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_good;

  uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ttl_rx_i  (ttl_rx_i),
    .rx_data   (rx_data),
    .recv_flag (recv_flag),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Edge counter and line history: hist[n] is the line level seen at edge n.
  always @(posedge clk) begin
    if (cyc + 1 < HIST) hist[cyc+1] <= ttl_rx_i;
    cyc <= cyc + 1;
  end

  // Strobe recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (recv_flag) rq.push_back('{cyc, rx_data});
    if (frame_err) eq.push_back(cyc);
    if (recv_flag && frame_err) both_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame with t-clock bits; p is the first edge seeing the start bit.
  task automatic send_frame(input logic [7:0] b, input int t, input logic stop, output int p);
    ttl_rx_i = 1'b0;
    p = cyc + 1;
    wait_cyc(t);
    for (int k = 0; k < 8; k++) begin
      ttl_rx_i = b[k];
      wait_cyc(t);
    end
    ttl_rx_i = stop;
    wait_cyc(t);
    ttl_rx_i = 1'b1;
  endtask

  // Outcome predicted from the sample-instant rules: the FSM is in START from
  // p+3, and the synchronised value used at edge n is the line level at n-2.
  function automatic void model(input int p, output bit ok, output bit err,
                                output logic [7:0] d, output int t);
    int s;
    s   = p + 3;
    ok  = 1'b0;
    err = 1'b0;
    d   = '0;
    t   = s + HALF + 9 * BIT - 1;
    if (hist[s+HALF-1-2]) return;
    for (int k = 0; k < 8; k++) d[k] = hist[s+HALF+(k+1)*BIT-1-2];
    ok  = hist[t-2];
    err = !ok;
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    ttl_rx_i = 1'b1;
    wait_cyc(4);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (recv_flag !== 1'b0) begin errors++; $display("FAIL reset_recv_flag got=%b exp=0", recv_flag); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    wait_cyc(6);
    last_good = 8'h00;
  endtask

  task automatic test_single();
    int p;
    rq.delete(); eq.delete();
    send_frame(8'hA5, BIT, 1'b1, p);
    wait_cyc(20);
    checks++;
    if (rq.size() != 1) begin
      errors++; $display("FAIL single_count got=%0d exp=1", rq.size());
    end else begin
      checks++; if (rq[0].t != p + 2 + (1 + HALF + 9 * BIT - 1)) begin errors++; $display("FAIL single_time got=%0d exp=%0d", rq[0].t, p + 2 + (1 + HALF + 9 * BIT - 1)); end
      checks++; if (rq[0].d !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", rq[0].d); end
    end
    checks++; if (eq.size() != 0) begin errors++; $display("FAIL single_ferr got=%0d exp=0", eq.size()); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_hold got=%h exp=a5", rx_data); end
    last_good = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h55};
    int p [3];
    bit ok, err;
    logic [7:0] d;
    int t;
    rq.delete(); eq.delete();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], BIT, 1'b1, p[i]);
    wait_cyc(20);
    checks++;
    if (rq.size() != 3) begin
      errors++; $display("FAIL b2b_count got=%0d exp=3", rq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        model(p[i], ok, err, d, t);
        checks++; if (rq[i].d !== bytes[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rq[i].d, bytes[i]); end
        checks++; if (rq[i].t != t) begin errors++; $display("FAIL b2b_time[%0d] got=%0d exp=%0d", i, rq[i].t, t); end
        if (i > 0) begin
          checks++; if (rq[i].t - rq[i-1].t != 10 * BIT) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, rq[i].t - rq[i-1].t, 10 * BIT); end
        end
      end
    end
    checks++; if (eq.size() != 0) begin errors++; $display("FAIL b2b_ferr got=%0d exp=0", eq.size()); end
    last_good = 8'h55;
  endtask

  task automatic test_frame_err();
    int p, t;
    bit ok, err;
    logic [7:0] d;
    rq.delete(); eq.delete();
    send_frame(8'h3C, BIT, 1'b0, p);
    wait_cyc(20);
    model(p, ok, err, d, t);
    checks++;
    if (eq.size() != 1) begin
      errors++; $display("FAIL ferr_count got=%0d exp=1", eq.size());
    end else begin
      checks++; if (eq[0] != t) begin errors++; $display("FAIL ferr_time got=%0d exp=%0d", eq[0], t); end
    end
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL ferr_recv got=%0d exp=0", rq.size()); end
    checks++; if (rx_data !== last_good) begin errors++; $display("FAIL ferr_hold got=%h exp=%h", rx_data, last_good); end
  endtask

  task automatic test_glitch();
    int p;
    rq.delete(); eq.delete();
    ttl_rx_i = 1'b0;
    p = cyc + 1;
    wait_cyc(3);
    ttl_rx_i = 1'b1;
    wait_cyc(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got=%b exp=1 at=%0d", busy, cyc - p); end
    wait_cyc(cyc < p + 12 ? p + 12 - cyc : 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got=%b exp=0 at=%0d", busy, cyc - p); end
    wait_cyc(10);
    checks++; if (rq.size() + eq.size() != 0) begin errors++; $display("FAIL glitch_flags got=%0d exp=0", rq.size() + eq.size()); end
    checks++; if (rx_data !== last_good) begin errors++; $display("FAIL glitch_hold got=%h exp=%h", rx_data, last_good); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'hC3;
    int p, t;
    bit ok, err;
    logic [7:0] d;
    rq.delete(); eq.delete();
    ttl_rx_i = 1'b0;
    wait_cyc(BIT);
    for (int k = 0; k < 4; k++) begin
      ttl_rx_i = b[k];
      wait_cyc(BIT);
    end
    ttl_rx_i = b[4];
    wait_cyc(BIT / 2);
    rst_n = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_rx_data got=%h exp=00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if ({recv_flag, frame_err} !== 2'b00) begin errors++; $display("FAIL rmid_flags got=%b exp=00", {recv_flag, frame_err}); end
    ttl_rx_i = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
    checks++; if (rq.size() + eq.size() != 0) begin errors++; $display("FAIL rmid_after got=%0d exp=0", rq.size() + eq.size()); end
    send_frame(8'h81, BIT, 1'b1, p);
    wait_cyc(20);
    model(p, ok, err, d, t);
    checks++;
    if (rq.size() != 1) begin
      errors++; $display("FAIL rmid_next_count got=%0d exp=1", rq.size());
    end else begin
      checks++; if (rq[0].d !== d || d !== 8'h81) begin errors++; $display("FAIL rmid_next_data got=%h exp=81", rq[0].d); end
    end
    last_good = 8'h81;
  endtask

  task automatic test_baud_skew();
    int periods [2] = '{15, 17};
    int p, t;
    bit ok, err;
    logic [7:0] d;
    for (int i = 0; i < 2; i++) begin
      rq.delete(); eq.delete();
      send_frame(8'h96, periods[i], 1'b1, p);
      wait_cyc(30);
      // The model, not the nominal byte, decides: short bits drift sample points late.
      model(p, ok, err, d, t);
      checks++; if (rq.size() != int'(ok)) begin errors++; $display("FAIL skew%0d_recv got=%0d exp=%0d", periods[i], rq.size(), ok); end
      checks++; if (eq.size() != int'(err)) begin errors++; $display("FAIL skew%0d_ferr got=%0d exp=%0d", periods[i], eq.size(), err); end
      if (ok && rq.size() == 1) begin
        checks++; if (rq[0].d !== d) begin errors++; $display("FAIL skew%0d_data got=%h exp=%h", periods[i], rq[0].d, d); end
        last_good = d;
      end
    end
  endtask

  task automatic test_random();
    int p [6];
    logic [7:0] b [6];
    bit good [6];
    bit ok, err;
    logic [7:0] d;
    int t;
    rq.delete(); eq.delete();
    for (int i = 0; i < 6; i++) begin
      b[i]    = 8'($urandom);
      good[i] = ($urandom_range(3, 0) != 0);
      send_frame(b[i], BIT, good[i], p[i]);
      wait_cyc(good[i] ? $urandom_range(4, 0) : $urandom_range(5, 2));
    end
    wait_cyc(20);
    for (int i = 0; i < 6; i++) begin
      model(p[i], ok, err, d, t);
      if (ok) begin
        checks++;
        if (rq.size() == 0) begin
          errors++; $display("FAIL rand_missing[%0d] got=none exp=%h", i, d);
        end else begin
          rx_ev_t e;
          e = rq.pop_front();
          checks++; if (e.d !== b[i]) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, e.d, b[i]); end
          checks++; if (e.t != t) begin errors++; $display("FAIL rand_time[%0d] got=%0d exp=%0d", i, e.t, t); end
          last_good = b[i];
        end
      end else begin
        checks++;
        if (eq.size() == 0) begin
          errors++; $display("FAIL rand_ferr_missing[%0d] got=none exp=%0d", i, t);
        end else begin
          int et;
          et = eq.pop_front();
          checks++; if (et != t) begin errors++; $display("FAIL rand_ferr_time[%0d] got=%0d exp=%0d", i, et, t); end
        end
      end
    end
    checks++; if (rq.size() + eq.size() != 0) begin errors++; $display("FAIL rand_extra got=%0d exp=0", rq.size() + eq.size()); end
    checks++; if (rx_data !== last_good) begin errors++; $display("FAIL rand_hold got=%h exp=%h", rx_data, last_good); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL flag_exclusive got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_baud_skew();
    test_random();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
